// File: rtl/ahblite_sram_slave.sv
// AHB-Lite subordinate backed by a word-organised on-chip SRAM.
// Adds WAIT_STATES wait cycles per OKAY transfer; out-of-range or misaligned accesses get a two-cycle ERROR.
module ahblite_sram_slave #(
  parameter int unsigned HADDR_WIDTH = 32,
  parameter int unsigned HDATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL_i,
  input  logic [1:0]             HTRANS_i,
  input  logic [2:0]             HBURST_i,
  input  logic [2:0]             HSIZE_i,
  input  logic                   HWRITE_i,
  input  logic [HADDR_WIDTH-1:0] HADDR_i,
  input  logic [HDATA_WIDTH-1:0] HWDATA_i,
  input  logic                   HREADY_i,
  output logic [HDATA_WIDTH-1:0] HRDATA_o,
  output logic                   HREADYOUT_o,
  output logic                   HRESP_o
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam logic [HADDR_WIDTH-1:0] AddrLimit = HADDR_WIDTH'(4 * MEM_DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW+1:0]   addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;

  logic [HDATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                   accept, addr_err, mem_we;
  logic [3:0]             be;
  logic [IdxW-1:0]        widx;

  // Burst type and the BUSY/SEQ distinction do not affect this responder.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST_i, HTRANS_i[0]};

  assign widx = addr_q[IdxW+1:2];

  always_comb begin
    accept   = (state_q inside {StIdle, StData, StErr2}) & HSEL_i & HREADY_i & HTRANS_i[1];
    addr_err = (HADDR_i >= AddrLimit) | HSIZE_i[2] | (HSIZE_i == 3'b011) |
               ((HSIZE_i == 3'b001) & HADDR_i[0]) |
               ((HSIZE_i == 3'b010) & (HADDR_i[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (accept) begin
      addr_d  = HADDR_i[IdxW+1:0];
      size_d  = HSIZE_i[1:0];
      write_d = HWRITE_i;
    end
    unique case (state_q)
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StData;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        if (!accept) begin
          state_d = StIdle;
        end else if (addr_err) begin
          state_d = StErr1;
        end else if (WAIT_STATES != 0) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = StData;
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT_o = !(state_q inside {StWait, StErr1});
    HRESP_o     = state_q inside {StErr1, StErr2};
    HRDATA_o    = ((state_q == StData) && !write_q) ? mem_q[widx] : '0;
    mem_we      = (state_q == StData) && write_q;
    unique case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= HWDATA_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Bench for ahblite_sram_slave: two instances (0 and 2 wait states) driven by one pipelined
// AHB-Lite master, checked cycle by cycle against a byte-lane memory model.
module tb_ahblite_sram_slave;

  localparam int unsigned Depth = 256;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_dut;
  logic        hsel, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hburst, hsize;
  logic [31:0] haddr, hwdata;
  logic        ro0, ro2, rs0, rs2;
  logic [31:0] rd0, rd2;
  logic        hready, hresp;
  logic [31:0] hrdata;

  logic [31:0] mdl [2][Depth];
  xfer_t       q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign hready = sel_dut ? ro2 : ro0;
  assign hresp  = sel_dut ? rs2 : rs0;
  assign hrdata = sel_dut ? rd2 : rd0;

  ahblite_sram_slave #(
    .HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(Depth), .WAIT_STATES(0)
  ) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL_i(hsel & ~sel_dut), .HTRANS_i(htrans),
    .HBURST_i(hburst), .HSIZE_i(hsize), .HWRITE_i(hwrite), .HADDR_i(haddr),
    .HWDATA_i(hwdata), .HREADY_i(ro0), .HRDATA_o(rd0), .HREADYOUT_o(ro0), .HRESP_o(rs0)
  );

  ahblite_sram_slave #(
    .HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(Depth), .WAIT_STATES(2)
  ) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL_i(hsel & sel_dut), .HTRANS_i(htrans),
    .HBURST_i(hburst), .HSIZE_i(hsize), .HWRITE_i(hwrite), .HADDR_i(haddr),
    .HWDATA_i(hwdata), .HREADY_i(ro2), .HRDATA_o(rd2), .HREADYOUT_o(ro2), .HRESP_o(rs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t mk(input logic s, input logic [1:0] t, input logic w,
                               input logic [2:0] z, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.sel = s; x.trans = t; x.wr = w; x.size = z; x.addr = a; x.wdata = d;
    x.burst = 3'b000;
    return x;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] z);
    if (z > 3'd2) return 1'b1;
    if (a >= 32'(4 * Depth)) return 1'b1;
    return (a % (32'd1 << z)) != 0;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] z,
                             input logic [31:0] wd);
    int w, lo;
    w  = int'(a >> 2);
    lo = int'(a % 4);
    for (int b = lo; b < lo + (1 << z); b++) mdl[d][w][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic drive(input xfer_t x);
    hsel = x.sel; htrans = x.trans; hburst = x.burst; hwrite = x.wr;
    hsize = x.size; haddr = x.addr;
  endtask

  // Pipelined master: the address held while HREADY is low; each data phase checked every cycle.
  task automatic run(output int cycles);
    xfer_t cur, dph, filler;
    bit    acc, dvalid, cur_filler, real_x, err, exp_rdy, finished;
    int    i, c, d, ws;
    logic [31:0] exp_rd;
    cycles = 0;
    filler = mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    d  = int'(sel_dut);
    ws = sel_dut ? 2 : 0;
    if (q.size() == 0) return;
    cur = q[0]; drive(cur); i = 1;
    cur_filler = 0; dvalid = 0; c = 0; finished = 0;
    acc = hready;
    for (int guard = 0; guard < 4000; guard++) begin
      @(posedge clk); #1;
      if (acc && !cur_filler) begin
        dph = cur; dvalid = 1; c = 0; hwdata = cur.wdata;
      end
      if (acc) begin
        if (i < q.size()) begin
          cur = q[i]; i++;
        end else begin
          cur = filler; cur_filler = 1;
        end
        drive(cur);
      end
      if (dvalid) begin
        real_x = dph.sel && dph.trans[1];
        err    = real_x && is_err(dph.addr, dph.size);
        if (!real_x)  exp_rdy = (c == 0);
        else if (err) exp_rdy = (c == 1);
        else          exp_rdy = (c == ws);
        exp_rd = (real_x && !err && !dph.wr && exp_rdy) ? mdl[d][dph.addr >> 2] : 32'h0;
        check("hreadyout", {31'b0, hready}, {31'b0, exp_rdy});
        check("hresp", {31'b0, hresp}, {31'b0, err});
        check("hrdata", hrdata, exp_rd);
        if (real_x) cycles++;
        c++;
        if (hready) begin
          if (real_x && !err && dph.wr) model_write(d, dph.addr, dph.size, dph.wdata);
          dvalid = 0;
        end else if (c > ws + 2) begin
          check("data_phase_timeout", {31'b0, hready}, 32'h1);
          q.delete();
          return;
        end
      end
      acc = hready;
      if (cur_filler && !dvalid) begin
        finished = 1;
        break;
      end
    end
    check("run_bound", {31'b0, finished}, 32'h1);
    q.delete();
  endtask

  task automatic fill_mem();
    for (int w = 0; w < Depth; w++) q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'(w * 4), $urandom));
  endtask

  task automatic rand_q(input int n);
    logic [2:0]  z;
    logic [31:0] a;
    int          r;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      z = (r == 9) ? 3'd3 : 3'(r % 3);
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * Depth - 1));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << z) - 32'd1);
      q.push_back(mk($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), z, a, $urandom));
    end
  endtask

  initial begin
    int cyc;
    xfer_t x;
    rst_n = 1'b0; sel_dut = 1'b0; hwdata = 32'h0;
    drive(mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", {31'b0, ro0}, 32'h1);
    check("rst_resp0", {31'b0, rs0}, 32'h0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_ready2", {31'b0, ro2}, 32'h1);
    check("rst_resp2", {31'b0, rs2}, 32'h0);
    check("rst_rdata2", rd2, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      sel_dut = 1'(d);
      fill_mem();
      run(cyc);
    end

    // Zero wait states: back-to-back write/read, lane merging, errors, non-transfers.
    sel_dut = 1'b0;
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h11, 32'h5555AA55 | 32'h0000AA00));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h12, 32'h12349999));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    run(cyc);
    check("merged_word", mdl[0][4], 32'h1234AA00);

    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h02, 32'h0));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'(4 * Depth), 32'h0));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h00, 32'h0BADF00D));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h01, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd3, 32'h00, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h00, 32'h0));
    run(cyc);
    check("err_no_write", mdl[0][0], 32'h0BADF00D);

    q.push_back(mk(1'b1, 2'b00, 1'b1, 3'd2, 32'h40, 32'h11111111));
    q.push_back(mk(1'b1, 2'b01, 1'b1, 3'd2, 32'h40, 32'h22222222));
    q.push_back(mk(1'b0, 2'b10, 1'b1, 3'd2, 32'h40, 32'h33333333));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0));
    run(cyc);
    rand_q(300);
    run(cyc);

    // Two wait states: single read latency and an INCR4 burst.
    sel_dut = 1'b1;
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    run(cyc);
    check("read_cycles_ws2", 32'(cyc), 32'd3);
    for (int k = 0; k < 4; k++) begin
      x = mk(1'b1, (k == 0) ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h20 + 32'(4 * k), 32'h0);
      x.burst = 3'b011;
      q.push_back(x);
    end
    run(cyc);
    check("incr4_cycles", 32'(cyc), 32'd12);
    rand_q(150);
    run(cyc);

    // Reset during the wait states of a write aborts it.
    drive(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0));
    @(posedge clk); #1;
    check("wait_before_reset", {31'b0, hready}, 32'h0);
    hwdata = ~mdl[1][12];
    drive(mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
    rst_n = 1'b0;
    #1;
    check("reset_ready", {31'b0, hready}, 32'h1);
    check("reset_resp", {31'b0, hresp}, 32'h0);
    check("reset_rdata", hrdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h30, 32'h0));
    run(cyc);
    sel_dut = 1'b0;
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    run(cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
